dual_request_dispatcher: RTL and testbench

//  Collects single-cycle request pulses from N sources into a sticky pending vector.

---
 rtl/dual_request_dispatcher.sv | 84 ++++++++
 tb/tb_dual_request_dispatcher.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dual_request_dispatcher.sv
// Sticky request collector that launches the two highest pending indices as one pair, 1-cycle latency pending->out.
// Pair holds while out_valid & ~out_ready; pending keeps collecting; back-to-back launch when out_ready stays high.
module dual_request_dispatcher #(
  parameter int N = 12,
  parameter int CW = 16,
  localparam int W = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_in,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_first,
  output logic [W-1:0]  out_second,
  output logic          out_second_v,
  output logic [N-1:0]  pending,
  output logic [CW-1:0] dispatch_cnt
);

  typedef enum logic [1:0] {IDLE, ARMED, HELD, STREAM} state_t;
  state_t state;

  logic [W-1:0] f, s;
  logic [N-1:0] rest, cleared, pending_nx;
  logic         sv, launch, accept, valid_nx;

  always_comb begin
    f = '0;
    for (int i = 0; i < N; i++)
      if (pending[i]) f = W'(i);
    rest = pending;
    rest[f] = 1'b0;
    s = '0;
    for (int i = 0; i < N; i++)
      if (rest[i]) s = W'(i);
    // anything left after removing f means at least two bits were pending
    sv = |rest;
    launch = (|pending) & (~out_valid | out_ready) & ~flush;
    accept = out_valid & out_ready;
    cleared = '0;
    if (launch) begin
      cleared[f] = 1'b1;
      if (sv) cleared[s] = 1'b1;
    end
    pending_nx = (pending & ~cleared) | req_in;
    if (flush) valid_nx = 1'b0;
    else if (launch) valid_nx = 1'b1;
    else if (accept) valid_nx = 1'b0;
    else valid_nx = out_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending      <= '0;
      out_valid    <= 1'b0;
      out_first    <= '0;
      out_second   <= '0;
      out_second_v <= 1'b0;
      dispatch_cnt <= '0;
      state        <= IDLE;
    end else begin
      if (accept && !flush && dispatch_cnt != {CW{1'b1}})
        dispatch_cnt <= dispatch_cnt + 1'b1;
      if (flush) begin
        pending      <= req_in;
        out_valid    <= 1'b0;
        out_second_v <= 1'b0;
        state        <= (|req_in) ? ARMED : IDLE;
      end else begin
        pending   <= pending_nx;
        out_valid <= valid_nx;
        if (launch) begin
          out_first    <= f;
          out_second   <= sv ? s : '0;
          out_second_v <= sv;
        end
        if (valid_nx) state <= (|pending_nx) ? STREAM : HELD;
        else          state <= (|pending_nx) ? ARMED : IDLE;
      end
    end
  end

endmodule

// File: tb/tb_dual_request_dispatcher.sv
// Scoreboard bench: expected pairs derived from each request pattern, compared on every accepted handshake.
module tb_dual_request_dispatcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] req_in = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [3:0]  out_first, out_second;
  logic        out_second_v;
  logic [11:0] pending;
  logic [15:0] dispatch_cnt;

  typedef struct {
    logic [3:0] f;
    logic [3:0] s;
    logic       v;
  } pair_t;

  pair_t sb[$];
  int    n_chk = 0;
  int    n_err = 0;
  int    exp_cnt = 0;

  dual_request_dispatcher dut (
    .clk(clk), .rst(rst), .req_in(req_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_first(out_first),
    .out_second(out_second), .out_second_v(out_second_v),
    .pending(pending), .dispatch_cnt(dispatch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected emission: set bits in descending order, grouped two at a time.
  task automatic push_pairs(input logic [11:0] p);
    int idx[$];
    for (int i = 11; i >= 0; i--)
      if (p[i]) idx.push_back(i);
    for (int k = 0; k < idx.size(); k += 2) begin
      pair_t e;
      e.f = 4'(idx[k]);
      if (k + 1 < idx.size()) begin
        e.s = 4'(idx[k+1]);
        e.v = 1'b1;
      end else begin
        e.s = 4'd0;
        e.v = 1'b0;
      end
      sb.push_back(e);
    end
  endtask

  // Samples the handshake mid-cycle, then advances to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        pair_t e;
        e = sb.pop_front();
        chk("pair_first", 32'(out_first), 32'(e.f));
        chk("pair_second", 32'(out_second), 32'(e.s));
        chk("pair_second_v", 32'(out_second_v), 32'(e.v));
        if (exp_cnt < 65535) exp_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input bit rand_ready);
    int budget;
    budget = 0;
    while ((out_valid || pending != 0) && budget < 60) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      tick();
      budget++;
    end
    chk({tag, "_drained"}, 32'(budget < 60), 32'd1);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    chk({tag, "_cnt"}, 32'(dispatch_cnt), 32'(exp_cnt));
  endtask

  initial begin
    // 1: reset
    repeat (5) tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_cnt", 32'(dispatch_cnt), 32'd0);
    chk("rst_first", 32'(out_first), 32'd0);
    chk("rst_second_v", 32'(out_second_v), 32'd0);
    rst = 1'b0;
    tick();

    // 2: two-bit + one-bit emission
    out_ready = 1'b1;
    req_in = 12'h821;
    push_pairs(12'h821);
    tick();
    req_in = 12'h000;
    chk("t2_pending0", 32'(pending), 32'h821);
    chk("t2_valid0", 32'(out_valid), 32'd0);
    tick();
    chk("t2_pending1", 32'(pending), 32'h001);
    chk("t2_valid1", 32'(out_valid), 32'd1);
    tick();
    chk("t2_pending2", 32'(pending), 32'h000);
    tick();
    chk("t2_valid_end", 32'(out_valid), 32'd0);
    chk("t2_cnt", 32'(dispatch_cnt), 32'd2);

    // 3: backpressure holds the pair
    out_ready = 1'b0;
    req_in = 12'h010;
    push_pairs(12'h010);
    tick();
    req_in = 12'h000;
    tick();
    for (int c = 0; c < 4; c++) begin
      chk("t3_valid", 32'(out_valid), 32'd1);
      chk("t3_first", 32'(out_first), 32'd4);
      chk("t3_second_v", 32'(out_second_v), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("t3_cnt", 32'(dispatch_cnt), 32'd3);
    chk("t3_valid_end", 32'(out_valid), 32'd0);

    // 4: request re-arms the bit being cleared
    req_in = 12'h300;
    tick();
    req_in = 12'h200;
    push_pairs(12'h300);
    push_pairs(12'h200);
    tick();
    req_in = 12'h000;
    chk("t4_pending", 32'(pending), 32'h200);
    chk("t4_first", 32'(out_first), 32'd9);
    chk("t4_second", 32'(out_second), 32'd8);
    drain("t4", 1'b0);

    // 5: flush with a same-cycle request
    out_ready = 1'b0;
    req_in = 12'h0F0;
    tick();
    tick();
    chk("t5_pre_valid", 32'(out_valid), 32'd1);
    chk("t5_pre_pending", 32'(pending), 32'h0F0);
    flush = 1'b1;
    req_in = 12'h001;
    tick();
    flush = 1'b0;
    req_in = 12'h000;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_pending", 32'(pending), 32'h001);
    chk("t5_second_v", 32'(out_second_v), 32'd0);
    chk("t5_cnt", 32'(dispatch_cnt), 32'(exp_cnt));
    push_pairs(12'h001);
    out_ready = 1'b1;
    drain("t5", 1'b0);

    // 6: full pattern sweep with random backpressure and one mid-pattern reset
    for (int p = 0; p < 4096; p++) begin
      req_in = 12'(p);
      out_ready = ($urandom_range(0, 3) != 0);
      push_pairs(12'(p));
      tick();
      req_in = 12'h000;
      if (p == 12'h5A5) begin
        out_ready = 1'b0;
        tick();
        rst = 1'b1;
        #2;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_pending", 32'(pending), 32'd0);
        chk("t6_rst_cnt", 32'(dispatch_cnt), 32'd0);
        chk("t6_rst_first", 32'(out_first), 32'd0);
        chk("t6_rst_second", 32'(out_second), 32'd0);
        chk("t6_rst_second_v", 32'(out_second_v), 32'd0);
        sb.delete();
        exp_cnt = 0;
        tick();
        rst = 1'b0;
        tick();
      end
      drain("t6", 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
